// File: rtl/decompress_ctrl.sv
// Sequencer for the 8-lane decompress datapath: assembles d-byte groups from the
// packed byte stream, issues them to the datapath and writes one result word per group.
module decompress_ctrl #(
   parameter int NGROUPS = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        d_sel,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [3:0]        dc_d,
   output logic [7:0]        dc_in_d1,
   output logic [31:0]       dc_in_d4,
   output logic [79:0]       dc_in_d10,
   input  logic [95:0]       dc_out,
   output logic              coef_we,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [95:0]       coef_wdata
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_r;
   logic [2:0]        state_s;
   logic [3:0]        d_r;
   logic [ADDR_W-1:0] grp_r;
   logic [3:0]        byte_r;
   logic [79:0]       pack_r;
   logic              err_r;
   logic              legal_s;
   logic              last_byte_s;
   logic              last_grp_s;

   assign legal_s     = (d_sel == 4'd1) || (d_sel == 4'd4) || (d_sel == 4'd10);
   assign last_byte_s = (byte_r == (d_r - 4'd1));
   assign last_grp_s  = (grp_r == ADDR_W'(NGROUPS - 1));

   // Outputs are decoded from registered state; coef_we is additionally gated by abort
   assign busy       = (state_r == S_FILL) || (state_r == S_ISSUE) || (state_r == S_WRITE);
   assign in_ready   = (state_r == S_FILL);
   assign done       = (state_r == S_DONE);
   assign coef_we    = (state_r == S_WRITE) && !abort;
   assign err        = err_r;
   assign coef_addr  = grp_r;
   assign coef_wdata = dc_out;
   assign dc_d       = d_r;
   assign dc_in_d1   = pack_r[7:0];
   assign dc_in_d4   = pack_r[31:0];
   assign dc_in_d10  = pack_r;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start && legal_s) state_s = S_FILL;
            else                  state_s = S_IDLE;
         end
         S_FILL: begin
            if (abort)                        state_s = S_IDLE;
            else if (in_valid && last_byte_s) state_s = S_ISSUE;
            else                              state_s = S_FILL;
         end
         S_ISSUE: begin
            if (abort) state_s = S_IDLE;
            else       state_s = S_WRITE;
         end
         S_WRITE: begin
            if (abort)           state_s = S_IDLE;
            else if (last_grp_s) state_s = S_DONE;
            else                 state_s = S_FILL;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // State, counters and the little-endian byte pack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         d_r     <= 4'd0;
         grp_r   <= '0;
         byte_r  <= 4'd0;
         pack_r  <= 80'd0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         err_r   <= (state_r == S_IDLE) && start && !legal_s;
         case (state_r)
            S_IDLE: begin
               if (start && legal_s) begin
                  d_r    <= d_sel;
                  grp_r  <= '0;
                  byte_r <= 4'd0;
                  pack_r <= 80'd0;
               end
            end
            S_FILL: begin
               if (!abort && in_valid) begin
                  pack_r[8*byte_r +: 8] <= in_data;
                  byte_r <= last_byte_s ? 4'd0 : byte_r + 4'd1;
               end
            end
            S_WRITE: begin
               if (!abort && !last_grp_s) grp_r <= grp_r + ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decompress_ctrl.sv
// Directed bench for decompress_ctrl with a behavioural 1-cycle decompress datapath.
module tb_decompress_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort, in_valid;
   logic [3:0]  d_sel;
   logic [7:0]  in_data;
   logic        busy, done, err, in_ready, coef_we;
   logic [3:0]  dc_d;
   logic [7:0]  dc_in_d1;
   logic [31:0] dc_in_d4;
   logic [79:0] dc_in_d10;
   logic [95:0] dc_out, coef_wdata;
   logic [4:0]  coef_addr;

   decompress_ctrl #(.NGROUPS(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .d_sel(d_sel), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .dc_d(dc_d), .dc_in_d1(dc_in_d1), .dc_in_d4(dc_in_d4), .dc_in_d10(dc_in_d10),
      .dc_out(dc_out), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   always #5 clk = ~clk;

   // Datapath model: registers pack and d every cycle, lane = floor(x*3329 / 2^d)
   function automatic logic [95:0] decomp(input logic [79:0] p, input logic [3:0] d);
      logic [95:0] r;
      int x;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (d == 4'd1)      x = int'(p[i]);
         else if (d == 4'd4) x = int'(p[4*i +: 4]);
         else                x = int'(p[10*i +: 10]);
         r[12*i +: 12] = 12'((x * 3329) >> d);
      end
      return r;
   endfunction

   logic [79:0] dp_pack;
   logic [3:0]  dp_d;
   always @(posedge clk) begin
      dp_pack <= dc_in_d10;
      dp_d    <= dc_d;
   end
   always_comb dc_out = decomp(dp_pack, dp_d);

   // Coefficient RAM model with write-order tracking
   logic [95:0] mem [0:31];
   int          hits [0:31];
   int          wr_cnt, order_err, exp_addr;
   bit          clr_req = 1'b0;
   always @(negedge clk) begin
      if (clr_req) begin
         wr_cnt = 0; order_err = 0; exp_addr = 0;
         for (int i = 0; i < 32; i++) begin hits[i] = 0; mem[i] = '0; end
      end else if (coef_we === 1'b1) begin
         if (int'(coef_addr) != exp_addr) order_err++;
         exp_addr++;
         wr_cnt++;
         hits[coef_addr]++;
         mem[coef_addr] = coef_wdata;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] stream [0:319];
   int  done_cyc;
   bit  seen_done, busy_at_done;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ram();
      clr_req = 1'b1;
      @(negedge clk);
      #1 clr_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // Drive one run: start edge, then feed bytes cycle by cycle until done or a bound
   task automatic run(input logic [3:0] d, input int gap, input int limit, input int max_cyc,
                      input int rst_addr, input bit mid_start);
      int idx, cyc;
      bit acc, stop;
      idx = 0; cyc = 0; stop = 1'b0;
      seen_done = 1'b0; done_cyc = -1; busy_at_done = 1'b1;
      start = 1'b1; d_sel = d;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      while (!stop && cyc < max_cyc) begin
         in_valid = (idx < limit) && ((gap == 0) || ($urandom_range(99) >= gap));
         in_data  = stream[idx % 320];
         start    = mid_start && (cyc == 40);
         d_sel    = start ? 4'd4 : d;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (done) begin
            seen_done = 1'b1; done_cyc = cyc; busy_at_done = busy; stop = 1'b1;
         end
         if (rst_addr >= 0 && coef_we && int'(coef_addr) == rst_addr) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_coef_we", 96'(coef_we), 96'd0);
            chk("rst_busy", 96'(busy), 96'd0);
            chk("rst_in_ready", 96'(in_ready), 96'd0);
            chk("rst_addr", 96'(coef_addr), 96'd0);
            chk("rst_dc_d", 96'(dc_d), 96'd0);
            chk("rst_pack", 96'(dc_in_d10), 96'd0);
            stop = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) idx++;
      end
      in_valid = 1'b0; start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; d_sel = 4'd0; in_data = 8'd0;
      #12;
      chk("reset_busy", 96'(busy), 96'd0);
      chk("reset_done", 96'(done), 96'd0);
      chk("reset_err", 96'(err), 96'd0);
      chk("reset_in_ready", 96'(in_ready), 96'd0);
      chk("reset_coef_we", 96'(coef_we), 96'd0);
      chk("reset_addr", 96'(coef_addr), 96'd0);
      chk("reset_dc_d", 96'(dc_d), 96'd0);
      chk("reset_pack", 96'(dc_in_d10), 96'd0);
      @(posedge clk); #1 rst = 1'b0;
      clear_ram();

      // Illegal d_sel
      start = 1'b1; d_sel = 4'd3;
      @(posedge clk); #1 start = 1'b0;
      chk("err_pulse", 96'(err), 96'd1);
      chk("err_busy", 96'(busy), 96'd0);
      chk("err_in_ready", 96'(in_ready), 96'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", 96'(err), 96'd0);
      chk("err_no_writes", 96'(wr_cnt), 96'd0);

      // d=1: 0xA5 then zeros, done 96 edges after the start edge
      for (int i = 0; i < 320; i++) stream[i] = 8'h00;
      stream[0] = 8'hA5;
      run(4'd1, 0, 320, 400, -1, 1'b0);
      chk("d1_done_seen", 96'(seen_done), 96'd1);
      chk("d1_done_cycle", 96'(done_cyc), 96'd96);
      chk("d1_busy_in_done", 96'(busy_at_done), 96'd0);
      @(negedge clk);
      chk("d1_done_width", 96'(done), 96'd0);
      chk("d1_word0", mem[0], {12'd1664, 12'd0, 12'd1664, 12'd0, 12'd0, 12'd1664, 12'd0, 12'd1664});
      for (int i = 1; i < 32; i++) chk($sformatf("d1_word%0d", i), mem[i], 96'd0);
      chk("d1_wr_cnt", 96'(wr_cnt), 96'd32);
      chk("d1_dc_d_held", 96'(dc_d), 96'd1);
      @(posedge clk); #1;
      clear_ram();

      // d=4 abort during group 5 fill (22 bytes supplied, then stall)
      for (int i = 0; i < 320; i++) stream[i] = 8'h3C;
      run(4'd4, 0, 22, 40, -1, 1'b0);
      chk("ab_busy_before", 96'(busy), 96'd1);
      chk("ab_in_ready_before", 96'(in_ready), 96'd1);
      chk("ab_writes_before", 96'(wr_cnt), 96'd5);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("ab_busy_after", 96'(busy), 96'd0);
      chk("ab_in_ready_after", 96'(in_ready), 96'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("ab_no_done", 96'(seen_done), 96'd0);
      chk("ab_no_more_writes", 96'(wr_cnt), 96'd5);
      @(posedge clk); #1;
      clear_ram();

      // Restart d=4 with start and abort together; fresh group 0 then 0xFF
      for (int i = 0; i < 320; i++) stream[i] = 8'hFF;
      stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56; stream[3] = 8'h78;
      abort = 1'b1;
      run(4'd4, 0, 320, 400, -1, 1'b0);
      chk("d4_done_seen", 96'(seen_done), 96'd1);
      chk("d4_done_cycle", 96'(done_cyc), 96'd192);
      chk("d4_word0", mem[0], {12'd1456, 12'd1664, 12'd1040, 12'd1248, 12'd624, 12'd832, 12'd208, 12'd416});
      for (int i = 1; i < 32; i++) chk($sformatf("d4_word%0d", i), mem[i], {8{12'd3120}});
      chk("d4_wr_cnt", 96'(wr_cnt), 96'd32);
      chk("d4_order", 96'(order_err), 96'd0);
      for (int i = 0; i < 32; i++) chk($sformatf("d4_hits%0d", i), 96'(hits[i]), 96'd1);
      @(posedge clk); #1;
      clear_ram();

      // d=10 all 0xFF with random gaps and a stray start while busy
      for (int i = 0; i < 320; i++) stream[i] = 8'hFF;
      run(4'd10, 30, 320, 3000, -1, 1'b1);
      chk("d10_done_seen", 96'(seen_done), 96'd1);
      chk("d10_dc_d", 96'(dc_d), 96'd10);
      for (int i = 0; i < 32; i++) chk($sformatf("d10_word%0d", i), mem[i], {8{12'd3325}});
      chk("d10_wr_cnt", 96'(wr_cnt), 96'd32);
      chk("d10_order", 96'(order_err), 96'd0);
      @(posedge clk); #1;
      clear_ram();

      // Reset in the write of group 10; earlier words stay in RAM
      for (int i = 0; i < 320; i++) stream[i] = 8'h00;
      run(4'd1, 0, 320, 400, 10, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 96'(busy), 96'd0);
      chk("post_rst_done", 96'(done), 96'd0);
      for (int i = 0; i < 10; i++) chk($sformatf("rst_kept%0d", i), 96'(hits[i]), 96'd1);
      chk("rst_order", 96'(order_err), 96'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
